cpu_port_pins: RTL and testbench

//  Pin-level model of the 6510 on-chip I/O port ($00 DDR / $01 data), downstream of the port registers.

---
 rtl/cpu_port_pins_pkg.sv | 15 +
 rtl/cpu_port_float_bit.sv | 31 +++
 rtl/cpu_port_pins.sv | 78 +++++++
 tb/tb_cpu_port_pins.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_port_pins_pkg.sv
// Shared definitions for the 6510 on-chip I/O port: pin indices and the reset pin byte.
package cpu_port_pins_pkg;

   localparam int CPUPORT_LORAM      = 0;
   localparam int CPUPORT_HIRAM      = 1;
   localparam int CPUPORT_CHAREN     = 2;
   localparam int CPUPORT_CASS_WRT   = 3;
   localparam int CPUPORT_CASS_SENSE = 4;
   localparam int CPUPORT_CASS_MOTOR = 5;

   localparam logic [7:0] CPUPORT_RESET_PINS = 8'h3F;

   localparam int PORT_W = 8;

endpackage

// File: rtl/cpu_port_float_bit.sv
// One unconnected port bit: remembers its last driven level while it is an input,
// then decays to 0 once the fade counter has run out.
module cpu_port_float_bit #(
   parameter int              FADE_W      = 24,
   parameter logic [FADE_W-1:0] FADE_CYCLES = 24'd350000
) (
   input  logic clk,
   input  logic reset,
   input  logic ddr,
   input  logic value,
   output logic hold
);

   logic [FADE_W-1:0] cnt;

   // Driven: track value and rearm fade. Input: count down, then drop the held level.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold <= 1'b0;
         cnt  <= '0;
      end else if (ddr) begin
         hold <= value;
         cnt  <= FADE_CYCLES;
      end else if (cnt != '0) begin
         cnt  <= cnt - {{(FADE_W-1){1'b0}}, 1'b1};
      end else begin
         hold <= 1'b0;
      end
   end

endmodule

// File: rtl/cpu_port_pins.sv
// Pin-level view of the 6510 I/O port: resolves direction, pulls, cassette sense and
// floating-bit decay into one registered pin byte that drives banking, cassette and $01 reads.
module cpu_port_pins
   import cpu_port_pins_pkg::*;
#(
   parameter int                FADE_W      = 24,
   parameter logic [FADE_W-1:0] FADE_CYCLES = 24'd350000,
   parameter logic [7:0]        PULL_MASK   = 8'h17,
   parameter logic [7:0]        FLOAT_MASK  = 8'hC0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] cpuport_ddr,
   input  logic [7:0] cpuport_value,
   input  logic       cass_sense_n,
   output logic [7:0] pins_o,
   output logic       loram,
   output logic       hiram,
   output logic       charen,
   output logic       cass_wrt,
   output logic       cass_motor
);

   logic [1:0]        sense_sync;
   logic [PORT_W-1:0] hold;
   logic [PORT_W-1:0] pin_d;
   logic [PORT_W-1:0] pin_q;

   // Two-flop synchroniser for the asynchronous cassette switch; idles released (1).
   always_ff @(posedge clk) begin
      if (reset) sense_sync <= 2'b11;
      else       sense_sync <= {sense_sync[0], cass_sense_n};
   end

   // Hold/decay cell only on bits with no external drive; others never use hold.
   for (genvar i = 0; i < PORT_W; i++) begin : g_bit
      if (FLOAT_MASK[i]) begin : g_float
         cpu_port_float_bit #(
            .FADE_W      (FADE_W),
            .FADE_CYCLES (FADE_CYCLES)
         ) u_float (
            .clk   (clk),
            .reset (reset),
            .ddr   (cpuport_ddr[i]),
            .value (cpuport_value[i]),
            .hold  (hold[i])
         );
      end else begin : g_fixed
         assign hold[i] = 1'b0;
      end
   end

   // Effective level per pin: outputs follow the data register, inputs see sense/hold/pulls.
   always_comb begin
      pin_d = '0;
      for (int i = 0; i < PORT_W; i++) begin
         if (cpuport_ddr[i])              pin_d[i] = cpuport_value[i];
         else if (i == CPUPORT_CASS_SENSE) pin_d[i] = sense_sync[1];
         else if (FLOAT_MASK[i])          pin_d[i] = hold[i];
         else                             pin_d[i] = PULL_MASK[i];
      end
   end

   // Single pin register so every output changes on the same edge.
   always_ff @(posedge clk) begin
      if (reset) pin_q <= CPUPORT_RESET_PINS;
      else       pin_q <= pin_d;
   end

   assign pins_o     = pin_q;
   assign loram      = pin_q[CPUPORT_LORAM];
   assign hiram      = pin_q[CPUPORT_HIRAM];
   assign charen     = pin_q[CPUPORT_CHAREN];
   assign cass_wrt   = pin_q[CPUPORT_CASS_WRT];
   // Motor transistor inverts the port line: pin low = motor on.
   assign cass_motor = ~pin_q[CPUPORT_CASS_MOTOR];

endmodule

// File: tb/tb_cpu_port_pins.sv
// Scoreboard bench for cpu_port_pins: the stimulus process queues expected output
// words tagged with the cycle they must appear in; a monitor compares them each cycle.
module tb_cpu_port_pins;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] cpuport_ddr;
   logic [7:0] cpuport_value;
   logic       cass_sense_n;
   logic [7:0] pins_o;
   logic       loram, hiram, charen, cass_wrt, cass_motor;

   cpu_port_pins #(
      .FADE_W      (8),
      .FADE_CYCLES (8'd16),
      .PULL_MASK   (8'h17),
      .FLOAT_MASK  (8'hC0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cpuport_ddr   (cpuport_ddr),
      .cpuport_value (cpuport_value),
      .cass_sense_n  (cass_sense_n),
      .pins_o        (pins_o),
      .loram         (loram),
      .hiram         (hiram),
      .charen        (charen),
      .cass_wrt      (cass_wrt),
      .cass_motor    (cass_motor)
   );

   always #5 clk = ~clk;

   // Output word: {cass_motor, cass_wrt, charen, hiram, loram, pins_o}
   typedef struct {
      int          cyc;
      logic [12:0] mask;
      logic [12:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   bit   done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Full expected word for a given pin byte (motor is active-low on pin 5).
   function automatic logic [12:0] full(input logic [7:0] p);
      return {~p[5], p[3], p[2], p[1], p[0], p};
   endfunction

   task automatic expect_full(input int c, input logic [7:0] p, input string nm);
      exp_t e;
      e.cyc = c; e.mask = 13'h1FFF; e.val = full(p); e.name = nm;
      sb.push_back(e);
   endtask

   task automatic expect_hi(input int c, input logic [1:0] b76, input string nm);
      exp_t e;
      e.cyc = c; e.mask = 13'h00C0; e.val = {5'b0, b76, 6'b0}; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every queued expectation whose cycle is now.
   always @(negedge clk) begin
      logic [12:0] act;
      act = {cass_motor, cass_wrt, charen, hiram, loram, pins_o};
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            n_total++;
            if ((act & sb[i].mask) === (sb[i].val & sb[i].mask)) n_pass++;
            else $display("FAIL %s cyc=%0d got=%h want=%h mask=%h",
                          sb[i].name, cyc, act, sb[i].val, sb[i].mask);
            sb.delete(i);
         end
      end
   end

   // Float bits driven high for 4 cycles then released; returns release cycle M.
   task automatic drive_high_then_release(output int m);
      cpuport_ddr = 8'hC0; cpuport_value = 8'hC0;
      step(4);
      cpuport_ddr = 8'h00;
      m = cyc;
   endtask

   initial begin
      int n, m;
      reset = 1'b1; cpuport_ddr = 8'hFF; cpuport_value = 8'h3F; cass_sense_n = 1'b1;

      // 1: reset state
      step(2);
      reset = 1'b0;
      expect_full(cyc, 8'h3F, "reset");
      step(2);

      // 2: all outputs, one-cycle latency
      n = cyc;
      cpuport_value = 8'h35;
      expect_full(n, 8'h3F, "pre_write");
      expect_full(n + 1, 8'h35, "write_35");
      step(2);
      n = cyc;
      cpuport_value = 8'h15;
      expect_full(n + 1, 8'h15, "write_15_motor_on");
      step(2);

      // 3: inputs with pulls, then cassette sense through the synchroniser
      cpuport_ddr = 8'h00;
      expect_full(cyc + 1, 8'h17, "inputs_pulled");
      step(3);
      n = cyc;
      cass_sense_n = 1'b0;
      expect_full(n + 1, 8'h17, "sense_n1");
      expect_full(n + 2, 8'h17, "sense_n2");
      expect_full(n + 3, 8'h07, "sense_n3");
      step(4);
      cass_sense_n = 1'b1;
      step(4);

      // 4: hold then decay; a value write while input must not matter
      drive_high_then_release(m);
      for (int k = 1; k <= 17; k++) expect_hi(m + k, 2'b11, "fade_hold");
      for (int k = 18; k <= 20; k++) expect_hi(m + k, 2'b00, "fade_decay");
      expect_full(m + 1, 8'hD7, "fade_full");
      step(3);
      cpuport_value = 8'h00;
      step(2);
      cpuport_value = 8'hC0;
      step(16);

      // 5: re-drive mid-fade rearms the full interval
      drive_high_then_release(m);
      for (int k = 1; k <= 29; k++) expect_hi(m + k, 2'b11, "rearm_hold");
      for (int k = 30; k <= 31; k++) expect_hi(m + k, 2'b00, "rearm_decay");
      step(10);
      cpuport_ddr = 8'hC0;
      step(2);
      cpuport_ddr = 8'h00;
      step(21);

      // 6: reset mid-fade wipes the held level
      drive_high_then_release(m);
      for (int k = 1; k <= 5; k++) expect_hi(m + k, 2'b11, "pre_reset_hold");
      expect_full(m + 6, 8'h3F, "midfade_reset");
      expect_full(m + 7, 8'h3F, "midfade_reset2");
      for (int k = 8; k <= 30; k++) expect_full(m + k, 8'h17, "post_reset_clear");
      step(5);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(25);

      // anything still queued was never compared
      while (sb.size() != 0) begin
         n_total++;
         $display("FAIL %s never_checked cyc=%0d want=%h", sb[0].name, sb[0].cyc, sb[0].val);
         void'(sb.pop_front());
      end
      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Watchdog
   initial begin
      #100000;
      if (!done) begin
         $display("FAIL watchdog timeout cyc=%0d", cyc);
         $fatal(1);
      end
   end

endmodule
